mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: Busy duration of mult and multu.
REQ-002 Parameter DIV_CYCLES, default 10: Busy duration of div and divu.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  begin a mult/div operation; driven by the decoder's MDU_Start.
REQ-006 Op  input  3  operation select: 0 mult, 1 multu, 2 div, 3 divu.
REQ-007 HI_Write  input  1  mthi request; write A to HI.
REQ-008 LO_Write  input  1  mtlo request; write A to LO.
REQ-009 Flush  input  1  exception/eret flush of the E-stage instruction; suppresses this cycle's requests.
REQ-010 A  input  32  rs operand; dividend, or mthi/mtlo source.
REQ-011 B  input  32  rt operand; divisor.
REQ-012 Busy  output  1  operation in flight; the hazard unit stalls MDU-class instructions on (Start | Busy).
REQ-013 HI  output  32  architectural HI register, read by mfhi.
REQ-014 LO  output  32  architectural LO register, read by mflo.

Function
REQ-015 Two states:
- IDLE: cnt==0.
- BUSY: cnt!=0.
- Busy SHALL be combinational (cnt!=0).
REQ-016 IDLE->BUSY on an edge with Start=1, Flush=0, Op<=3:
- Compute the result from A/B sampled at that edge into internal hold registers.
- Load cnt with MULT_CYCLES (Op 0/1) or DIV_CYCLES (Op 2/3).
REQ-017 In BUSY, each edge SHALL decrement cnt.
REQ-018 On the edge where cnt goes 1->0, HI/LO SHALL take the held result.
- Busy SHALL be 1 for exactly N cycles after the start edge.
- New HI/LO SHALL become visible in the same cycle Busy falls.
REQ-019 mult: {HI,LO} = signed 64-bit product of A and B. multu: the same, unsigned.
REQ-020 div: LO = signed quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
REQ-021 divu: LO = unsigned quotient; HI = unsigned remainder.
REQ-022 div with A=0x80000000, B=0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-023 Divide by zero (B=0, div or divu):
- Busy SHALL still run DIV_CYCLES.
- HI and LO SHALL keep their prior values.
REQ-024 In IDLE with Start=0 and Flush=0:
- HI_Write=1 SHALL set HI=A at that edge.
- LO_Write=1 SHALL set LO=A at that edge.
- If both are set, both writes SHALL occur.
- Latency SHALL be 1 cycle; Busy SHALL not assert.
REQ-025 Start and HI_Write/LO_Write in the same cycle: Start SHALL win; the moves SHALL be ignored.
REQ-026 Start, HI_Write and LO_Write SHALL be ignored while Busy=1; the in-flight operation is unaffected.
REQ-027 Flush=1 SHALL suppress that cycle's Start, HI_Write and LO_Write.
- Flush SHALL NOT abort an operation already in BUSY; it completes and commits.
REQ-028 Start with Op>3 SHALL be ignored: no state change.
REQ-029 Back-to-back operations:
- Start is accepted in the first cycle after Busy falls.
- Its cnt loads at that edge, so Busy has a single-cycle low gap.
REQ-030 No operand or result path SHALL be combinational from input to output; HI and LO SHALL be registers.

Reset
REQ-031 reset=1 at an edge SHALL set HI=0, LO=0, cnt=0, hold registers=0; Busy=0 the following cycle.
REQ-032 reset SHALL override Start, HI_Write, LO_Write and Flush.
REQ-033 reset during BUSY SHALL abandon the operation; HI/LO SHALL NOT receive its result.

Verification
REQ-034 mult, A=0xFFFFFFFE, B=3:
- Busy high 5 cycles.
- Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 multu, A=0xFFFFFFFE, B=3 -> HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
REQ-036 div, A=-7 (0xFFFFFFF9), B=2:
- Busy high 10 cycles.
- Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu with the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
REQ-037 Precondition HI=0x11, LO=0x22; div with B=0:
- Busy high 10 cycles.
- HI=0x11, LO=0x22 unchanged.
- Then mthi A=0x55 -> HI=0x55 one cycle later.
REQ-038 Start is rejected in each of these cases:
- Start with Flush=1 -> no Busy, HI/LO unchanged.
- Start at busy cycle 3 of a mult -> ignored; the original mult result commits at cycle 5.
REQ-039 div started, then reset at busy cycle 4 -> Busy=0, HI=LO=0; no later commit.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO.
// Multi-cycle busy window; the result is computed at start and committed when the count expires.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic        HI_Write,
  input  logic        LO_Write,
  input  logic        Flush,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   hh_q, hh_d, lh_q, lh_d;
  logic          wr_q, wr_d;

  logic          idle, go, mv;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   bsafe, ua, ub, uq, ur, sq, sr;
  logic [31:0]   res_hi, res_lo;
  logic          res_ok;

  assign idle = (cnt_q == '0);
  assign Busy = ~idle;
  assign HI   = hi_q;
  assign LO   = lo_q;

  assign go = idle & Start & ~Flush & (Op <= 3'd3);
  assign mv = idle & ~Start & ~Flush;

  // Result datapath; signed divide goes through magnitudes so that
  // 0x80000000 / -1 wraps cleanly instead of overflowing.
  always_comb begin
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'd0, A} * {32'd0, B};
    bsafe  = (B == 32'd0) ? 32'd1 : B;
    ua     = A[31] ? (32'd0 - A) : A;
    ub     = bsafe[31] ? (32'd0 - bsafe) : bsafe;
    uq     = ua / ub;
    ur     = ua % ub;
    sq     = (A[31] ^ bsafe[31]) ? (32'd0 - uq) : uq;
    sr     = A[31] ? (32'd0 - ur) : ur;
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_ok = 1'b1;
    case (Op[1:0])
      2'd0: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      2'd1: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      2'd2: begin
        res_hi = sr;
        res_lo = sq;
        res_ok = (B != 32'd0);
      end
      default: begin
        res_hi = A % bsafe;
        res_lo = A / bsafe;
        res_ok = (B != 32'd0);
      end
    endcase
  end

  // Next-state: start, count down and commit, or idle moves.
  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    hh_d  = hh_q;
    lh_d  = lh_q;
    wr_d  = wr_q;
    if (go) begin
      cnt_d = Op[1] ? DIV_CYCLES[CW-1:0] : MULT_CYCLES[CW-1:0];
      hh_d  = res_hi;
      lh_d  = res_lo;
      wr_d  = res_ok;
    end else if (!idle) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1) && wr_q) begin
        hi_d = hh_q;
        lo_d = lh_q;
      end
    end else if (mv) begin
      if (HI_Write) hi_d = A;
      if (LO_Write) lo_d = A;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      hh_q  <= 32'd0;
      lh_q  <= 32'd0;
      wr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      hh_q  <= hh_d;
      lh_q  <= lh_d;
      wr_q  <= wr_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu.
// Hand-computed HI/LO values and busy-window lengths.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  Op;
  logic        HI_Write;
  logic        LO_Write;
  logic        Flush;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_chk = 0;
  int n_fail = 0;

  mdu dut (
    .clk(clk),
    .reset(reset),
    .Start(Start),
    .Op(Op),
    .HI_Write(HI_Write),
    .LO_Write(LO_Write),
    .Flush(Flush),
    .A(A),
    .B(B),
    .Busy(Busy),
    .HI(HI),
    .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(string tag, logic [2:0] op,
                        logic [31:0] a, logic [31:0] b, int n,
                        logic [31:0] ehi, logic [31:0] elo);
    int c;
    Start = 1'b1; Op = op; A = a; B = b;
    tick();
    Start = 1'b0; A = 32'd0; B = 32'd0;
    c = 0;
    while (Busy && c < 200) begin
      c++;
      HI_Write = 1'b0;
      tick();
    end
    chk({tag, "_cyc"}, 32'(c), 32'(n));
    chk({tag, "_hi"}, HI, ehi);
    chk({tag, "_lo"}, LO, elo);
  endtask

  initial begin
    int c;
    reset = 1'b1; Start = 1'b0; Op = 3'd0;
    HI_Write = 1'b0; LO_Write = 1'b0; Flush = 1'b0;
    A = 32'd0; B = 32'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);

    run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);

    HI_Write = 1'b1; A = 32'h11; tick(); HI_Write = 1'b0;
    chk("mthi_hi", HI, 32'h11);
    chk("mthi_busy", 32'(Busy), 32'd0);
    LO_Write = 1'b1; A = 32'h22; tick(); LO_Write = 1'b0;
    chk("mtlo_lo", LO, 32'h22);
    chk("mtlo_hi", HI, 32'h11);

    run_op("div0", 3'd2, 32'd100, 32'd0, 10, 32'h11, 32'h22);
    HI_Write = 1'b1; A = 32'h55; tick(); HI_Write = 1'b0;
    chk("mthi55", HI, 32'h55);

    run_op("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);

    Start = 1'b1; Flush = 1'b1; Op = 3'd0; A = 32'd3; B = 32'd4;
    tick();
    Start = 1'b0; Flush = 1'b0;
    chk("flush_st_busy", 32'(Busy), 32'd0);
    chk("flush_st_hi", HI, 32'h0);
    chk("flush_st_lo", LO, 32'h80000000);

    HI_Write = 1'b1; LO_Write = 1'b1; Flush = 1'b1; A = 32'h77;
    tick();
    HI_Write = 1'b0; LO_Write = 1'b0; Flush = 1'b0;
    chk("flush_mv_hi", HI, 32'h0);
    chk("flush_mv_lo", LO, 32'h80000000);

    Start = 1'b1; Op = 3'd4; A = 32'd9; B = 32'd9;
    tick();
    Start = 1'b0;
    chk("op4_busy", 32'(Busy), 32'd0);
    chk("op4_lo", LO, 32'h80000000);

    HI_Write = 1'b1;
    run_op("st_mv", 3'd0, 32'd7, 32'd6, 5, 32'h0, 32'h2A);
    HI_Write = 1'b0;

    HI_Write = 1'b1; LO_Write = 1'b1; A = 32'h99;
    tick();
    HI_Write = 1'b0; LO_Write = 1'b0;
    chk("both_hi", HI, 32'h99);
    chk("both_lo", LO, 32'h99);

    Start = 1'b1; Op = 3'd0; A = 32'hFFFFFFFE; B = 32'd3;
    tick();
    Start = 1'b0;
    c = 0;
    while (Busy && c < 200) begin
      c++;
      if (c == 2) begin
        Start = 1'b1; Op = 3'd3; A = 32'd100; B = 32'd3;
        HI_Write = 1'b1; LO_Write = 1'b1;
      end else begin
        Start = 1'b0; HI_Write = 1'b0; LO_Write = 1'b0;
      end
      tick();
    end
    Start = 1'b0; HI_Write = 1'b0; LO_Write = 1'b0;
    chk("busy_st_cyc", 32'(c), 32'd5);
    chk("busy_st_hi", HI, 32'hFFFFFFFF);
    chk("busy_st_lo", LO, 32'hFFFFFFFA);

    Start = 1'b1; Op = 3'd0; A = 32'd5; B = 32'd5;
    tick();
    Start = 1'b0; Flush = 1'b1;
    c = 0;
    while (Busy && c < 200) begin
      c++;
      tick();
    end
    Flush = 1'b0;
    chk("flush_bsy_cyc", 32'(c), 32'd5);
    chk("flush_bsy_lo", LO, 32'd25);
    chk("flush_bsy_hi", HI, 32'd0);

    run_op("b2b_mul", 3'd0, 32'h10000, 32'h10000, 5, 32'd1, 32'd0);
    run_op("b2b_div", 3'd2, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    Start = 1'b1; Op = 3'd2; A = 32'd100; B = 32'd7;
    tick();
    Start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_bsy_busy", 32'(Busy), 32'd0);
    chk("rst_bsy_hi", HI, 32'd0);
    chk("rst_bsy_lo", LO, 32'd0);
    repeat (12) tick();
    chk("rst_late_hi", HI, 32'd0);
    chk("rst_late_lo", LO, 32'd0);
    chk("rst_late_busy", 32'(Busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
